uart_rx_engine: RTL and testbench

- UART receive engine inside the core, directly downstream of the technology-specific interface's synchronised-pin outputs.
- Deserialises the RX line into bytes using the same EIGHT/PEN/OHEL/BAUD configuration as the transmit engine.
- Presents each byte with a sticky ready flag plus parity, framing and overrun status for the core's read logic and LED status.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_rx_engine.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, baud table and bit-time helper
package uart_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } uart_state_t;

  localparam int unsigned BAUD_RATES [16] = '{
    300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
    115200, 230400, 460800, 921600, 921600, 921600, 921600, 921600
  };

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned bit_time(input longint unsigned clk_hz, input int unsigned idx);
    longint unsigned rate;
    rate = 64'(BAUD_RATES[idx[3:0]]);
    return 32'((clk_hz + rate / 64'd2) / rate);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable down-counter giving mid-bit and end-of-bit ticks
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] bt,
  output logic             half_tick,
  output logic             sample_tick,
  output logic             bit_tick
);

  logic [CNT_W-1:0] bt_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] mid;

  // The load cycle itself is position 0 of the bit, so the counter starts at BT-2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bt_q <= '0;
      cnt  <= '0;
    end else if (load) begin
      bt_q <= bt;
      cnt  <= bt - CNT_W'(2);
    end else if (cnt == '0) begin
      cnt <= bt_q - CNT_W'(1);
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign mid         = bt_q - CNT_W'(1) - (bt_q >> 1);
  assign half_tick   = (cnt == mid);
  assign sample_tick = (cnt == mid - CNT_W'(1));
  assign bit_tick    = (cnt == '0);

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART receive engine: sync, frame FSM, sticky status
// Define UART_RX_MAJORITY_VOTE_EN for a 2-of-3 vote around each mid-bit sample.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic [3:0] baud,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf,
  output logic       busy
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0] sync_q;
  logic              rx_s;
  logic              rx_prev;
  logic              fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_N-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_N-1];
  assign fall = rx_prev & ~rx_s;

  logic [CNT_W-1:0] bt_tab [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_bt
    localparam logic [CNT_W-1:0] BT_I = CNT_W'(bit_time(64'(CLK_HZ), gi));
    assign bt_tab[gi] = BT_I;
  end

  uart_state_t state;
  uart_state_t state_next;
  logic        start_det;
  logic        half_tick;
  logic        sample_tick;
  logic        bit_tick;

  uart_bit_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (start_det),
    .bt          (bt_tab[baud]),
    .half_tick   (half_tick),
    .sample_tick (sample_tick),
    .bit_tick    (bit_tick)
  );

  // Decisions are taken one clock after mid-bit so both sampling modes share timing.
  logic sample;
  logic s_mid;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rx_d1;
  logic s_pre;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_d1 <= 1'b1;
      s_pre <= 1'b1;
      s_mid <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      if (half_tick) begin
        s_pre <= rx_d1;
        s_mid <= rx_s;
      end
    end
  end

  assign sample = (s_pre & s_mid) | (s_pre & rx_s) | (s_mid & rx_s);
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_mid <= 1'b1;
    end else if (half_tick) begin
      s_mid <= rx_s;
    end
  end

  assign sample = s_mid;
`endif

  logic [3:0] bit_cnt;
  logic [3:0] nbits;
  logic [7:0] shreg;
  logic [7:0] data_byte;
  logic       eight_q;
  logic       pen_q;
  logic       ohel_q;
  logic       perr_q;
  logic       ferr_q;

  assign nbits     = eight_q ? 4'd8 : 4'd7;
  assign data_byte = eight_q ? shreg : {1'b0, shreg[7:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // bit_cnt counts bit boundaries since the start edge, so data bit i is taken at bit_cnt == i+1.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START:   if (sample_tick) state_next = sample ? IDLE : DATA;
      DATA:    if (sample_tick && bit_cnt == nbits) state_next = pen_q ? PARITY : STOP;
      PARITY:  if (sample_tick) state_next = STOP;
      STOP:    if (sample_tick) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      rx_data <= '0;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (start_det) begin
        eight_q <= eight;
        pen_q   <= pen;
        ohel_q  <= ohel;
        bit_cnt <= '0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
      end else if (bit_tick && state != IDLE) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (state == DATA && sample_tick) shreg <= {sample, shreg[7:1]};
      if (state == PARITY && sample_tick) perr_q <= ((^data_byte) ^ sample) != ohel_q;
      if (state == STOP && sample_tick) ferr_q <= ~sample;

      if (state == DONE) begin
        rx_data <= data_byte;
        rxrdy   <= 1'b1;
        perr    <= pen_q & perr_q;
        ferr    <= ferr_q;
        ovf     <= rxrdy & ~rx_read;
      end else if (rx_read && rxrdy) begin
        rxrdy <= 1'b0;
        perr  <= 1'b0;
        ferr  <= 1'b0;
        ovf   <= 1'b0;
      end

      busy <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - scoreboard bench for uart_rx_engine
module tb_uart_rx_engine;

  localparam int unsigned CLK_HZ_TB = 10000000;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic [3:0] baud;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rxrdy;
  logic       perr;
  logic       ferr;
  logic       ovf;
  logic       busy;

  uart_rx_engine #(
    .CLK_HZ      (CLK_HZ_TB),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .baud    (baud),
    .rx_read (rx_read),
    .rx_data (rx_data),
    .rxrdy   (rxrdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  function automatic int bt_of(input int rate);
    return (CLK_HZ_TB + rate / 2) / rate;
  endfunction

  task automatic push_exp(input logic v, input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    exp_t e;
    e.valid = v;
    e.data  = d;
    e.perr  = pe;
    e.ferr  = fe;
    e.ovf   = ov;
    sb.push_back(e);
  endtask

  // Each busy episode ends in exactly one scoreboard entry.
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (rst && busy_prev && !busy) begin
      check_eq("sb_pending", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("rdy", rxrdy, e.valid);
        if (e.valid) begin
          check_eq("data", rx_data, e.data);
          check_eq("perr", perr, e.perr);
          check_eq("ferr", ferr, e.ferr);
          check_eq("ovf", ovf, e.ovf);
        end
      end
    end
    busy_prev <= busy;
  end

  task automatic send_line(input int bt, input logic [7:0] d, input int nbits,
                           input logic with_par, input logic par, input logic stop_b);
    @(negedge clk);
    rx = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      repeat (bt) @(negedge clk);
    end
    if (with_par) begin
      rx = par;
      repeat (bt) @(negedge clk);
    end
    rx = stop_b;
    repeat (bt) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic frame(input int bt, input logic [7:0] d, input logic par,
                       input logic stop_b, input logic ovf_e);
    logic [7:0] dm;
    logic       pe;
    dm = eight ? d : (d & 8'h7F);
    pe = pen ? (((^dm) ^ par) != ohel) : 1'b0;
    push_exp(1'b1, dm, pe, ~stop_b, ovf_e);
    send_line(bt, d, eight ? 8 : 7, pen, par, stop_b);
  endtask

  // Decision for the stop bit lands one clock after its mid-bit; DONE follows, then commit.
  task automatic done_probe(input int bt, input int stop_idx, input logic pulse_read);
    int p;
    p = stop_idx * bt + (bt >> 1) + 1;
    @(negedge clk);
    repeat (p + 3) @(posedge clk);
    @(negedge clk);
    if (pulse_read) rx_read = 1'b1;
    else check_eq("lat_pre", rxrdy, 0);
    @(negedge clk);
    if (pulse_read) rx_read = 1'b0;
    else check_eq("lat_post", rxrdy, 1);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bt_fast;
    int bt_slow;
    bt_fast = bt_of(115200);
    bt_slow = bt_of(9600);

    rst = 1'b0; rx = 1'b1; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    baud = 4'd8; rx_read = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", {rx_data, rxrdy, perr, ferr, ovf, busy}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    fork
      frame(bt_fast, 8'hA5, 1'b0, 1'b1, 1'b0);
      done_probe(bt_fast, 9, 1'b0);
    join
    read_pulse();
    check_eq("read_clr", rxrdy, 0);
    check_eq("read_hold", rx_data, 8'hA5);

    eight = 1'b0; pen = 1'b1; ohel = 1'b0;
    frame(bt_fast, 8'h41, 1'b0, 1'b1, 1'b0);
    read_pulse();
    frame(bt_fast, 8'h41, 1'b1, 1'b1, 1'b0);
    read_pulse();
    ohel = 1'b1;
    frame(bt_fast, 8'h41, 1'b1, 1'b1, 1'b0);
    read_pulse();
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;

    frame(bt_fast, 8'h11, 1'b0, 1'b1, 1'b0);
    frame(bt_fast, 8'h22, 1'b0, 1'b1, 1'b1);
    read_pulse();
    check_eq("ovf_clr", ovf, 0);

    frame(bt_fast, 8'h33, 1'b0, 1'b1, 1'b0);
    fork
      frame(bt_fast, 8'h44, 1'b0, 1'b1, 1'b0);
      done_probe(bt_fast, 9, 1'b1);
    join
    read_pulse();

    frame(bt_fast, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    @(negedge clk);
    rx = 1'b0;
    repeat (bt_fast) @(negedge clk);
    rx = 1'b1;
    repeat (2 * bt_fast) @(negedge clk);
    check_eq("rst_busy_pre", busy, 1);
    check_eq("rst_rdy_pre", rxrdy, 1);
    #2 rst = 1'b0;
    #1 check_eq("rst_async", {rx_data, rxrdy, perr, ferr, ovf, busy}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    frame(bt_fast, 8'h5A, 1'b0, 1'b1, 1'b0);
    read_pulse();

    push_exp(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    repeat ((bt_fast * 3) / 10) @(negedge clk);
    rx = 1'b1;
    repeat (bt_fast) @(negedge clk);
    check_eq("glitch_rdy", rxrdy, 0);

    fork
      frame(bt_fast, 8'h96, 1'b0, 1'b1, 1'b0);
      begin
        repeat (3 * bt_fast) @(negedge clk);
        baud = 4'd4;
        eight = 1'b0;
      end
    join
    eight = 1'b1;
    read_pulse();
    frame(bt_slow, 8'hC3, 1'b0, 1'b1, 1'b0);
    read_pulse();

    baud = 4'd8;
    push_exp(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    repeat (12 * bt_fast) @(negedge clk);
    rx = 1'b1;
    repeat (3 * bt_fast) @(negedge clk);
    check_eq("brk_idle", busy, 0);
    check_eq("sb_drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
